// File: rtl/counter_pkg.sv
// counter_pkg: constants and helpers shared by the up/down counter family.
//   DEFAULT_WIDTH : default counter width in bits
//   UP_RST_VAL    : per-bit reset value for up-counting (count resets to 0)
//   DOWN_RST_VAL  : per-bit reset value for down-counting (count resets to all-ones)
//   op_e          : per-edge operation selected by the priority decoder
package counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  localparam bit UP_RST_VAL   = 1'b0;
  localparam bit DOWN_RST_VAL = 1'b1;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_COUNT = 2'd1,
    OP_LOAD  = 2'd2,
    OP_CLR   = 2'd3
  } op_e;

  // Priority: clear > load > count > hold.
  function automatic op_e decode_op(input logic clr, input logic load, input logic count);
    op_e op;
    if (clr)        op = OP_CLR;
    else if (load)  op = OP_LOAD;
    else if (count) op = OP_COUNT;
    else            op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/tff_en.sv
// tff_en: T flip-flop with toggle enable and synchronous set/clear override.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset, loads RST_VAL
//   t    : toggle enable
//   set  : synchronous set (loses to clr)
//   clr  : synchronous clear (highest synchronous priority)
//   q    : registered state
module tff_en
  import counter_pkg::*;
#(
  parameter bit RST_VAL = UP_RST_VAL
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic set,
  input  logic clr,
  output logic q
);

  // State cell: overrides win over toggle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     q <= RST_VAL;
    else if (clr) q <= 1'b0;
    else if (set) q <= 1'b1;
    else if (t)   q <= ~q;
  end

endmodule

// File: rtl/up_counter.sv
// up_counter: synchronous modulo-(MAX+1) up counter built from T flip-flops.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   en, cin  : count when both high; cin chains from the previous stage's cout
//   clr      : synchronous clear to 0 (top priority)
//   load     : synchronous parallel load of load_val (any value, even > MAX)
//   clr_ovf  : clears the sticky overflow flag
//   q        : current count
//   tc       : combinational, q >= MAX
//   cout     : combinational, tc & en & cin
//   wrap     : registered one-cycle pulse in the cycle after a count-induced wrap
//   ovf      : sticky overflow, set by wrap, cleared by clr_ovf (set wins)
module up_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned MAX   = (2 ** WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cin,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             cout,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic             count;
  logic             at_max;
  logic             wrap_evt;
  op_e              op;
  logic [WIDTH-1:0] low_ones;
  logic [WIDTH-1:0] tog;
  logic [WIDTH-1:0] set_v;
  logic [WIDTH-1:0] clr_v;

  assign count  = en & cin;
  // Anything above MAX (reachable only by load) behaves as terminal.
  assign at_max = (q >= MAX_V);
  assign tc     = at_max;
  assign cout   = at_max & count;
  assign op     = decode_op(clr, load, count);

  assign wrap_evt = (op == OP_COUNT) && at_max;

  // low_ones[i]: every bit below i is set, so bit i flips on increment.
  for (genvar i = 0; i < WIDTH; i++) begin : g_low
    if (i == 0) begin : g_lsb
      assign low_ones[i] = 1'b1;
    end else begin : g_upper
      assign low_ones[i] = &q[i-1:0];
    end
  end

  // Per-bit toggle enables and overrides for the selected operation.
  always_comb begin
    tog   = '0;
    set_v = '0;
    clr_v = '0;
    unique case (op)
      OP_CLR:   clr_v = '1;
      OP_LOAD: begin
        set_v = load_val;
        clr_v = ~load_val;
      end
      OP_COUNT: begin
        if (at_max) clr_v = '1;
        else        tog   = low_ones;
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_en #(
      .RST_VAL(UP_RST_VAL)
    ) u_tff (
      .clk(clk),
      .rst(rst),
      .t  (tog[i]),
      .set(set_v[i]),
      .clr(clr_v[i]),
      .q  (q[i])
    );
  end

  // Wrap pulse and sticky overflow; a wrap beats clr_ovf on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      wrap <= wrap_evt;
      if (wrap_evt)     ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

endmodule

// File: doc/up_counter.md
# up_counter

Synchronous, modulo-programmable up counter: the counting-up counterpart to the team's ripple down counter, built for use wherever an incrementing count is needed. All bits share one clock: state is held in T flip-flop cells with toggle enables, not a ripple chain. Supports synchronous clear and parallel load, plus carry-in/carry-out for cascading instances into wider counters. Reports terminal count, a registered wrap pulse, and a sticky overflow flag.

## Interface
- WIDTH, 4, counter width in bits (≥2)
- MAX, 2**WIDTH-1, terminal value; count sequence is 0..MAX, then 0
- clk  input  1  rising-edge clock, sole clock of the block
- rst  input  1  asynchronous, active-low reset
- en  input  1  count enable
- cin  input  1  cascade carry-in; tie 1 on the least-significant stage
- clr  input  1  synchronous clear to 0
- load  input  1  synchronous parallel load
- load_val  input  WIDTH  value captured on load
- clr_ovf  input  1  clears sticky overflow flag
- q  output  WIDTH  current count
- tc  output  1  combinational: q >= MAX
- cout  output  1  combinational: tc & en & cin; feeds next stage's cin
- wrap  output  1  registered one-cycle pulse, asserted the cycle after q wrapped to 0
- ovf  output  1  sticky: set on any wrap, cleared by clr_ovf

## Operation
- Reset (rst=0, asynchronous): q=0, wrap=0, ovf=0 immediately, with no clock edge required. tc and cout follow from q=0.
- Per-edge priority is clr > load > count > hold:
  - clr=1: q←0. No wrap is generated.
  - load=1: q←load_val. This is accepted even if load_val > MAX. No wrap is generated.
  - Count condition is en & cin:
    - If q < MAX: q←q+1.
    - If q >= MAX: q←0 and wrap is asserted next cycle.
  - Otherwise q holds.
- Out-of-range q (above MAX, reachable only via load): treated as terminal. tc=1, and the next count wraps to 0.
- MAX = 2**WIDTH-1 is natural binary rollover. Arithmetic is WIDTH bits and no intermediate carry is exposed.
- ovf: set on the edge where a wrap occurs. clr_ovf clears it. If a wrap and clr_ovf happen on the same edge, set wins.
- Cascading: stage N's cin is stage N-1's cout, and all stages share clk, en, clr and load. The result is a synchronous WIDTH·k counter with no ripple delay between stages.

## Timing
- q updates on the rising clk edge; there is no combinational path from en, load or clr to q.
- Count latency is 1 cycle from en&cin sampled high to q incremented.
- tc and cout are combinational from q, en and cin. They are valid in the same cycle and must be settled before the next edge.
- wrap: high for exactly one cycle, in the cycle where q=0 following a count-induced wrap. Back-to-back wraps (MAX=0 degenerate case is disallowed) cannot occur.
- Reset deassertion must be synchronised externally. The first count edge is the first rising edge after rst goes high.
- Reset mid-count: q returns to 0 asynchronously, and any pending wrap pulse is cancelled.

## Structure
- Shared package counter_pkg:
  - default WIDTH constant
  - counter reset-value constant (0 for up-counting, all-ones for down-counting)
- Sub-module tff_en: T flip-flop with toggle-enable input, synchronous set/clear override, async active-low reset, and a parameterised reset value.
  - up_counter instantiates WIDTH of these.
  - Bit i toggles when count & (all lower bits = 1) & q < MAX.
  - The wrap, load and clear paths drive each cell's override.
- Terminal compare, cout, the wrap register and the ovf register live in up_counter itself.

## Test plan
- Reset: drive rst=0 mid-run with q=7. Required: q=0, wrap=0, ovf=0 without waiting for a clock edge. Hold en=1 after release and check q=1,2,3 on successive edges.
- Modulo 10 (WIDTH=4, MAX=9): en=cin=1 for 12 edges. Required sequence is 1..9,0,1,2. tc=1 only while q=9. wrap is high for one cycle, during the cycle q=0. ovf=1 from then on.
- Load out of range (MAX=9): load load_val=12, then count once. Required: q=12 with tc=1, then q=0 with wrap=1. Load with load_val=5 and en=1 on the same edge gives q=5 (load beats count).
- Priority: clr=1, load=1 (load_val=3) and en=1 on the same edge with q=4. Required: q=0, no wrap.
- Sticky flag: wrap and clr_ovf on the same edge leaves ovf=1. clr_ovf alone next cycle gives ovf=0.
- Cascade: two WIDTH=4 instances chained through cout→cin, count from 0x0E for 3 edges. Required combined values 0x0F, 0x10, 0x11. Low stage wrap=1 only in the 0x10 cycle. High-stage q changes on the same edge as the low stage (no ripple lag).
